// File: rtl/weight_bram_loader.sv
// weight_bram_loader
//   Runtime loader for the CNN weight/vector memory. Accepts a valid/ready
//   stream of RAM_WIDTH-bit words and writes them into the address window
//   [LOAD_START_ADDR, LOAD_END_ADDR] of an internal block RAM. The RAM is
//   read through an asynchronous port that behaves like the read-only vector
//   memories in the datapath, so consumers see no difference.
// Ports:
//   clk, rst_n        clock (rising edge), async active-low reset
//   start, abort      begin a load / cancel an in-progress load
//   s_valid, s_data   stream word in; s_ready high while loading
//   addr_vector       consumer read address; dataOut = mem[addr_vector]
//   busy, done        in LOAD / window fully written
//   load_count        words accepted in the current or last load
module weight_bram_loader #(
  parameter int RAM_WIDTH            = 4,
  parameter int RAM_ADDR_BITS_VECTOR = 6,
  parameter int LOAD_START_ADDR      = 0,
  parameter int LOAD_END_ADDR        = 63
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic                            abort,
  input  logic                            s_valid,
  input  logic [RAM_WIDTH-1:0]            s_data,
  output logic                            s_ready,
  input  logic [RAM_ADDR_BITS_VECTOR-1:0] addr_vector,
  output logic [RAM_WIDTH-1:0]            dataOut,
  output logic                            busy,
  output logic                            done,
  output logic [RAM_ADDR_BITS_VECTOR:0]   load_count
);
  localparam int AW    = RAM_ADDR_BITS_VECTOR;
  localparam int CW    = RAM_ADDR_BITS_VECTOR + 1;
  localparam int DEPTH = 2 ** RAM_ADDR_BITS_VECTOR;

  localparam logic [AW-1:0] START_A = AW'(LOAD_START_ADDR);
  localparam logic [AW-1:0] END_A   = AW'(LOAD_END_ADDR);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [RAM_WIDTH-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [CW-1:0] load_count_q, load_count_d;
  logic          we;

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    load_count_d = load_count_q;
    we           = 1'b0;
    case (state_q)
      // start beats abort here; abort is meaningless outside LOAD
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          wr_addr_d    = START_A;
          load_count_d = '0;
        end
      end
      S_LOAD: begin
        // abort drops a beat offered in the same cycle
        if (abort) begin
          state_d = S_IDLE;
        end else if (s_valid) begin
          we           = 1'b1;
          load_count_d = load_count_q + CW'(1);
          // window end terminates the load, so wr_addr never wraps
          if (wr_addr_q == END_A) state_d = S_DONE;
          else                    wr_addr_d = wr_addr_q + AW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_addr_q    <= START_A;
      load_count_q <= '0;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      load_count_q <= load_count_d;
    end
  end

  // Block-RAM array: no reset, so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (we) mem[wr_addr_q] <= s_data;
  end

  assign dataOut    = mem[addr_vector];
  assign s_ready    = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD);
  assign done       = (state_q == S_DONE);
  assign load_count = load_count_q;
endmodule

// File: tb/tb_weight_bram_loader.sv
// Directed bench for weight_bram_loader: full-window instance (0..63) plus a
// small-window instance (5..7).
module tb_weight_bram_loader;
  localparam int W  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0, s_valid = 1'b0;
  logic [W-1:0]  s_data = '0;
  logic          s_ready, busy, done;
  logic [AW-1:0] addr_vector = '0;
  logic [W-1:0]  dataOut;
  logic [AW:0]   load_count;

  logic          w_start = 1'b0, w_abort = 1'b0, w_valid = 1'b0;
  logic [W-1:0]  w_data = '0;
  logic          w_ready, w_busy, w_done;
  logic [AW-1:0] w_addr = '0;
  logic [W-1:0]  w_dout;
  logic [AW:0]   w_count;
  logic [W-1:0]  snap [64];

  int passes = 0;
  int total  = 0;

  weight_bram_loader #(.RAM_WIDTH(W), .RAM_ADDR_BITS_VECTOR(AW),
                       .LOAD_START_ADDR(0), .LOAD_END_ADDR(63)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .addr_vector(addr_vector), .dataOut(dataOut),
    .busy(busy), .done(done), .load_count(load_count));

  weight_bram_loader #(.RAM_WIDTH(W), .RAM_ADDR_BITS_VECTOR(AW),
                       .LOAD_START_ADDR(5), .LOAD_END_ADDR(7)) u_win (
    .clk(clk), .rst_n(rst_n), .start(w_start), .abort(w_abort),
    .s_valid(w_valid), .s_data(w_data), .s_ready(w_ready),
    .addr_vector(w_addr), .dataOut(w_dout),
    .busy(w_busy), .done(w_done), .load_count(w_count));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [W-1:0] d);
    s_valid = 1'b1;
    s_data  = d;
    step();
  endtask

  task automatic rd(input int a, input logic [W-1:0] e, input string tag);
    addr_vector = AW'(a);
    #1;
    chk(tag, 32'(dataOut), 32'(e));
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(s_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_count", 32'(load_count), 0);
    chk("rst_w_busy", 32'(w_busy), 0);
    rst_n = 1'b1;
    step();

    // s_valid outside LOAD is ignored
    s_valid = 1'b1; s_data = 4'h5;
    step();
    s_valid = 1'b0;
    chk("idle_ready", 32'(s_ready), 0);
    chk("idle_count", 32'(load_count), 0);

    // Full load: i mod 16
    go();
    chk("start_busy", 32'(busy), 1);
    chk("start_ready", 32'(s_ready), 1);
    chk("start_count", 32'(load_count), 0);
    for (int i = 0; i < 64; i++) begin
      beat(W'(i % 16));
      if (i == 62) chk("full_done_early", 32'(done), 0);
    end
    s_valid = 1'b0;
    chk("full_done", 32'(done), 1);
    chk("full_busy", 32'(busy), 0);
    chk("full_ready", 32'(s_ready), 0);
    chk("full_count", 32'(load_count), 64);
    for (int i = 0; i < 64; i++) rd(i, W'(i % 16), "full_mem");

    // Restart after DONE: 0x3 then 0xC, with a stray start mid-load
    go();
    for (int i = 0; i < 64; i++) beat(4'h3);
    s_valid = 1'b0;
    chk("re1_done", 32'(done), 1);
    rd(17, 4'h3, "re1_mem");
    go();
    chk("re2_count0", 32'(load_count), 0);
    for (int i = 0; i < 64; i++) begin
      if (i == 30) start = 1'b1;
      beat(4'hC);
      start = 1'b0;
      if (i == 30) begin
        chk("re2_start_ign_count", 32'(load_count), 31);
        chk("re2_start_ign_busy", 32'(busy), 1);
      end
    end
    s_valid = 1'b0;
    chk("re2_done", 32'(done), 1);
    chk("re2_count", 32'(load_count), 64);
    for (int i = 0; i < 64; i++) rd(i, 4'hC, "re2_mem");

    // Abort mid-load together with an 11th valid word
    go();
    for (int i = 0; i < 10; i++) beat(4'hA);
    abort = 1'b1;
    beat(4'hA);
    abort = 1'b0;
    s_valid = 1'b0;
    chk("ab_busy", 32'(busy), 0);
    chk("ab_done", 32'(done), 0);
    chk("ab_ready", 32'(s_ready), 0);
    chk("ab_count", 32'(load_count), 10);
    for (int i = 0; i < 10; i++) rd(i, 4'hA, "ab_mem_written");
    rd(10, 4'hC, "ab_mem_addr10");
    rd(11, 4'hC, "ab_mem_addr11");
    // abort in IDLE is a no-op
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("ab_idle_count", 32'(load_count), 10);
    chk("ab_idle_busy", 32'(busy), 0);

    // Backpressure: s_valid 1,0,1,0...; also read-during-write at addr 0
    addr_vector = '0;
    go();
    chk("bp_old_before_write", 32'(dataOut), 32'hA);
    for (int k = 0; k < 127; k++) begin
      s_valid = (k % 2 == 0);
      s_data  = (k % 2 == 0) ? W'((k / 2) % 16) : 4'hF;
      step();
      if (k == 0) chk("bp_new_after_write", 32'(dataOut), 0);
      if (k == 1) chk("bp_gap_count", 32'(load_count), 1);
      if (k == 125) chk("bp_done_early", 32'(done), 0);
    end
    s_valid = 1'b0;
    chk("bp_done", 32'(done), 1);
    chk("bp_count", 32'(load_count), 64);
    for (int i = 0; i < 64; i++) rd(i, W'(i % 16), "bp_mem");

    // Async reset mid-load after 20 beats of 0x7
    go();
    for (int i = 0; i < 20; i++) beat(4'h7);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", 32'(busy), 0);
    chk("ar_ready", 32'(s_ready), 0);
    chk("ar_done", 32'(done), 0);
    chk("ar_count", 32'(load_count), 0);
    s_valid = 1'b0;
    #1 rst_n = 1'b1;
    step();
    chk("ar_post_busy", 32'(busy), 0);
    for (int i = 0; i < 20; i++) rd(i, 4'h7, "ar_mem_kept");
    rd(20, 4'h4, "ar_mem_addr20");

    // Window 5..7: snapshot prior contents, then load 9,A,B.
    // start and abort together in IDLE: start wins.
    for (int i = 0; i < 64; i++) begin
      w_addr = AW'(i);
      #1;
      snap[i] = w_dout;
    end
    step();
    w_start = 1'b1; w_abort = 1'b1;
    step();
    w_start = 1'b0; w_abort = 1'b0;
    chk("win_start_wins", 32'(w_busy), 1);
    w_valid = 1'b1; w_data = 4'h9;
    step();
    chk("win_done_b1", 32'(w_done), 0);
    w_data = 4'hA;
    step();
    chk("win_done_b2", 32'(w_done), 0);
    w_data = 4'hB;
    step();
    w_valid = 1'b0;
    chk("win_done", 32'(w_done), 1);
    chk("win_count", 32'(w_count), 3);
    chk("win_ready", 32'(w_ready), 0);
    for (int i = 0; i < 64; i++) begin
      w_addr = AW'(i);
      #1;
      if (i == 5)      chk("win_mem5", 32'(w_dout), 32'h9);
      else if (i == 6) chk("win_mem6", 32'(w_dout), 32'hA);
      else if (i == 7) chk("win_mem7", 32'(w_dout), 32'hB);
      else             chk("win_mem_outside", 32'(w_dout), 32'(snap[i]));
    end

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule

// File: doc/weight_bram_loader.md
# weight_bram_loader

Writer side of the CNN weight/vector memory. It accepts a stream of RAM_WIDTH-bit words over a valid/ready handshake and writes them into an address window of an internal block RAM. The same RAM is exposed through an asynchronous read port that is identical in behaviour to the read-only vector memories used by the CNN datapath. It replaces compile-time file initialisation with a runtime load from the host/UART side, so that the downstream consumers do not change.

## Interface
- RAM_WIDTH, 4, bits per stored word
- RAM_ADDR_BITS_VECTOR, 6, address width; depth = 2**RAM_ADDR_BITS_VECTOR
- LOAD_START_ADDR, 0, first address written by a load
- LOAD_END_ADDR, 63, last address written by a load; must be ≥ LOAD_START_ADDR and < depth

- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a load
- abort  in  1  cancel an in-progress load
- s_valid  in  1  stream word valid
- s_data  in  RAM_WIDTH  stream word
- s_ready  out  1  loader accepts a word this cycle
- addr_vector  in  RAM_ADDR_BITS_VECTOR  read address from the consumer
- dataOut  out  RAM_WIDTH  asynchronous read data, mem[addr_vector]
- busy  out  1  high in LOAD
- done  out  1  high in DONE, meaning the window is fully written
- load_count  out  RAM_ADDR_BITS_VECTOR+1  words accepted in the current or last load

## Operation
- RAM: array of RAM_WIDTH × 2**RAM_ADDR_BITS_VECTOR, block-RAM style. Synchronous write, asynchronous read. Contents are not cleared by rst_n.
- FSM states: IDLE, LOAD, DONE.
- IDLE to LOAD on start: wr_addr ← LOAD_START_ADDR, load_count ← 0.
- DONE to LOAD on start: same as above, so a completed window can be reloaded.
- LOAD:
  - s_ready = 1.
  - A beat is accepted when s_valid && s_ready. On an accepted beat, mem[wr_addr] ← s_data and load_count increments.
  - If wr_addr == LOAD_END_ADDR on the accepted beat, go to DONE. Otherwise wr_addr ← wr_addr+1.
  - s_valid low means no write and no state change.
- start while in LOAD is ignored, with no restart.
- abort while in LOAD: go to IDLE. load_count holds its value and done stays 0. Words already written remain in memory.
- abort has priority over an accepted beat in the same cycle: that word is not written.
- abort in IDLE or DONE is ignored.
- start and abort asserted together in IDLE or DONE: start wins.
- s_ready = 0 in IDLE and DONE. s_valid is ignored there, and no write occurs.
- wr_addr never wraps. The window end forces DONE before any wrap.
- Single-word window (LOAD_START_ADDR == LOAD_END_ADDR): the first accepted beat goes to DONE.
- Addresses outside the window are never written.

## Timing
- Reset values: state IDLE, s_ready 0, busy 0, done 0, load_count 0, wr_addr LOAD_START_ADDR. dataOut stays combinational from memory.
- start sampled at edge N: busy = s_ready = 1 after edge N. The earliest beat is accepted at edge N+1.
- Throughput: one word per cycle while s_valid is held high. A full 64-word load takes 64 cycles from the first accepted beat.
- done rises in the cycle after the edge that accepts the last word. busy and s_ready fall in that same cycle.
- Write/read to the same address:
  - dataOut shows the old value before the write edge.
  - dataOut shows the new value after the write edge, with zero-cycle read latency once written.
- Reset asserted mid-load: outputs return to reset values immediately, asynchronously. The memory keeps any words already written.

## Test plan
- Full load: reset, start, stream s_data = i mod 16 for i = 0..63 with s_valid held high.
  - Required: done rises exactly 64 cycles after the first beat and load_count = 64.
  - Reading addr_vector = 0..63 returns 0,1,…,15,0,…
- Backpressure gaps: same stream with s_valid toggling 1,0,1,0.
  - Required: only valid cycles write, done arrives after 64 accepted beats, and memory contents are identical to the full-load case.
- Abort mid-load: accept 10 words of 0xA, then assert abort together with an 11th valid word.
  - Required: state IDLE, done = 0, load_count = 10, addresses 0–9 = 0xA, and address 10 is unchanged.
- Restart after DONE: complete a load with 0x3, then start and load 0xC.
  - Required: all addresses read 0xC.
  - start pulsed during the second load changes nothing.
- Window parameters LOAD_START_ADDR = 5, LOAD_END_ADDR = 7: preload the full RAM with 0x1, then load 0x9, 0xA, 0xB.
  - Required: addresses 5–7 = 9, A, B, all other addresses = 0x1, and done after 3 beats.
- Async reset mid-load: after 20 beats, pulse rst_n low between clock edges.
  - Required: busy, done, s_ready and load_count drop to 0 immediately, and addresses 0–19 keep their written data.
